// File: rtl/bcd_count_reverser_if.sv
// Bus bundle between the BCD counter, the count-down view generator and the display driver.
interface bcd_count_reverser_if;
    logic [7:0] RevIn;
    logic       ModeSel;
    logic [3:0] RevFromH;
    logic [3:0] RevFromL;
    logic [7:0] RevOut;
    logic       RevSat;

    modport master (
        output RevIn, ModeSel, RevFromH, RevFromL,
        input  RevOut, RevSat
    );

    modport slave (
        input  RevIn, ModeSel, RevFromH, RevFromL,
        output RevOut, RevSat
    );
endinterface

// File: rtl/bcd_count_reverser.sv
// Two-digit BCD count-down view: pass-through or per-digit (limit - count).
// The digits are independent, so there is no borrow between them. The result is registered.
module bcd_count_reverser #(
    parameter int unsigned MAX_DIGIT = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    bcd_count_reverser_if.slave    bus
);
    localparam int unsigned DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MAX_DIGIT);

    // Any out-of-range nibble is treated as the largest legal digit
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > MAX_D) ? MAX_D : d;
    endfunction

    logic [DIGIT_W-1:0] cnt_hi, cnt_lo, lim_hi, lim_lo;
    logic [7:0]         rev_out_d, rev_out_q;
    logic               rev_sat_d, rev_sat_q;

    always_comb begin
        cnt_hi = clamp_digit(bus.RevIn[7:4]);
        cnt_lo = clamp_digit(bus.RevIn[3:0]);
        lim_hi = clamp_digit(bus.RevFromH);
        lim_lo = clamp_digit(bus.RevFromL);
    end

    // Next result: a digit whose count exceeds its limit floors at 0 and flags saturation
    always_comb begin
        rev_out_d = {cnt_hi, cnt_lo};
        rev_sat_d = 1'b0;
        if (bus.ModeSel) begin
            if (cnt_hi > lim_hi) begin
                rev_out_d[7:4] = '0;
                rev_sat_d      = 1'b1;
            end else begin
                rev_out_d[7:4] = lim_hi - cnt_hi;
            end
            if (cnt_lo > lim_lo) begin
                rev_out_d[3:0] = '0;
                rev_sat_d      = 1'b1;
            end else begin
                rev_out_d[3:0] = lim_lo - cnt_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rev_out_q <= 8'h00;
            rev_sat_q <= 1'b0;
        end else begin
            rev_out_q <= rev_out_d;
            rev_sat_q <= rev_sat_d;
        end
    end

    assign bus.RevOut = rev_out_q;
    assign bus.RevSat = rev_sat_q;
endmodule

// File: tb/tb_bcd_count_reverser.sv
// Directed self-checking bench for bcd_count_reverser.
module tb_bcd_count_reverser;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    bcd_count_reverser_if bus ();

    bcd_count_reverser #(.MAX_DIGIT(9)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Drive on the falling edge, then let one rising edge register it and settle
    task automatic step(input logic [7:0] rin, input logic mode,
                        input logic [3:0] lh, input logic [3:0] ll);
        @(negedge clk);
        bus.RevIn    = rin;
        bus.ModeSel  = mode;
        bus.RevFromH = lh;
        bus.RevFromL = ll;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.RevIn = 8'h29; bus.ModeSel = 1'b0; bus.RevFromH = 4'h2; bus.RevFromL = 4'h9;
        #2;
        checks++;
        if (bus.RevOut !== 8'h00 || bus.RevSat !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: got %h/%b expected 00/0", bus.RevOut, bus.RevSat);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.RevOut !== 8'h29) begin
            errors++;
            $display("FAIL reset_preload: got %h expected 29", bus.RevOut);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.RevOut !== 8'h00 || bus.RevSat !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got %h/%b expected 00/0", bus.RevOut, bus.RevSat);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.RevOut !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: got %h expected 00", bus.RevOut);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.RevOut !== 8'h00) begin
            errors++;
            $display("FAIL reset_release_pre_edge: got %h expected 00", bus.RevOut);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.RevOut !== 8'h29) begin
            errors++;
            $display("FAIL reset_first_edge: got %h expected 29", bus.RevOut);
        end
    endtask

    task automatic test_passthrough();
        logic [7:0] vin [3]  = '{8'h25, 8'h39, 8'h3C};
        logic [7:0] vexp [3] = '{8'h25, 8'h39, 8'h39};
        for (int i = 0; i < 3; i++) begin
            step(vin[i], 1'b0, 4'h2, 4'h9);
            checks++;
            if (bus.RevOut !== vexp[i] || bus.RevSat !== 1'b0) begin
                errors++;
                $display("FAIL passthrough[%0d]: got %h/%b expected %h/0",
                         i, bus.RevOut, bus.RevSat, vexp[i]);
            end
        end
    endtask

    task automatic test_reverse();
        logic [7:0] vin [4]  = '{8'h25, 8'h10, 8'h00, 8'h29};
        logic [7:0] vexp [4] = '{8'h04, 8'h19, 8'h29, 8'h00};
        for (int i = 0; i < 4; i++) begin
            step(vin[i], 1'b1, 4'h2, 4'h9);
            checks++;
            if (bus.RevOut !== vexp[i] || bus.RevSat !== 1'b0) begin
                errors++;
                $display("FAIL reverse[%0d]: got %h/%b expected %h/0",
                         i, bus.RevOut, bus.RevSat, vexp[i]);
            end
        end
    endtask

    task automatic test_saturate();
        step(8'h35, 1'b1, 4'h2, 4'h9);
        checks++;
        if (bus.RevOut !== 8'h04 || bus.RevSat !== 1'b1) begin
            errors++;
            $display("FAIL sat_high: got %h/%b expected 04/1", bus.RevOut, bus.RevSat);
        end
        step(8'h2F, 1'b1, 4'h2, 4'h9);
        checks++;
        if (bus.RevOut !== 8'h00 || bus.RevSat !== 1'b0) begin
            errors++;
            $display("FAIL clamp_low: got %h/%b expected 00/0", bus.RevOut, bus.RevSat);
        end
        step(8'h17, 1'b1, 4'h3, 4'h4);
        checks++;
        if (bus.RevOut !== 8'h20 || bus.RevSat !== 1'b1) begin
            errors++;
            $display("FAIL sat_low: got %h/%b expected 20/1", bus.RevOut, bus.RevSat);
        end
        step(8'h00, 1'b1, 4'hF, 4'hA);
        checks++;
        if (bus.RevOut !== 8'h99 || bus.RevSat !== 1'b0) begin
            errors++;
            $display("FAIL clamp_limits: got %h/%b expected 99/0", bus.RevOut, bus.RevSat);
        end
        // Saturation flag must be cleared by reset too
        step(8'h35, 1'b1, 4'h2, 4'h9);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.RevSat !== 1'b0 || bus.RevOut !== 8'h00) begin
            errors++;
            $display("FAIL sat_reset: got %h/%b expected 00/0", bus.RevOut, bus.RevSat);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mode_toggle();
        logic       vmode [3] = '{1'b0, 1'b1, 1'b0};
        logic [7:0] vexp [3]  = '{8'h10, 8'h19, 8'h10};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.RevIn = 8'h10; bus.RevFromH = 4'h2; bus.RevFromL = 4'h9;
            bus.ModeSel = vmode[i];
            #1;
            if (i > 0) begin
                checks++;
                if (bus.RevOut !== vexp[i-1]) begin
                    errors++;
                    $display("FAIL toggle_pre_edge[%0d]: got %h expected %h",
                             i, bus.RevOut, vexp[i-1]);
                end
            end
            @(posedge clk); #1;
            checks++;
            if (bus.RevOut !== vexp[i] || bus.RevSat !== 1'b0) begin
                errors++;
                $display("FAIL toggle[%0d]: got %h/%b expected %h/0",
                         i, bus.RevOut, bus.RevSat, vexp[i]);
            end
        end
    endtask

    task automatic test_back_to_back_limits();
        step(8'h12, 1'b1, 4'h5, 4'h5);
        checks++;
        if (bus.RevOut !== 8'h43 || bus.RevSat !== 1'b0) begin
            errors++;
            $display("FAIL limits_55: got %h/%b expected 43/0", bus.RevOut, bus.RevSat);
        end
        step(8'h12, 1'b1, 4'h1, 4'h2);
        checks++;
        if (bus.RevOut !== 8'h00 || bus.RevSat !== 1'b0) begin
            errors++;
            $display("FAIL limits_12: got %h/%b expected 00/0", bus.RevOut, bus.RevSat);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_reverse();
        test_saturate();
        test_mode_toggle();
        test_back_to_back_limits();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
